// File: rtl/gemma_acc_pkg.sv
// Shared constants and FSM encoding for the INT8 systolic accelerator edge logic.
package gemma_acc_pkg;

    localparam int unsigned DEFAULT_N          = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_K_WIDTH    = 16;
    localparam int unsigned STATE_WIDTH        = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift line carrying {valid, data} for one skewed lane.
module skew_delay_line #(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  tap_valid,
    output logic [DATA_WIDTH-1:0] tap_data
);

    logic [DEPTH-1:0]                 valid_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

    // Shift valid and data together; stage 0 takes the new sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= sample_valid;
            data_q[0]  <= sample_data;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign tap_valid = valid_q[DEPTH-1];
    assign tap_data  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder: accepts one N-lane operand vector per beat, skews lane i by i
// cycles, and sequences one K-beat tile (clear, stream, drain, done) per start.
module systolic_skew_feeder
    import gemma_acc_pkg::*;
#(
    parameter int unsigned N          = DEFAULT_N,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned K_WIDTH    = DEFAULT_K_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_data,
    output logic [N*DATA_WIDTH-1:0] out_data,
    output logic [N-1:0]            out_valid,
    output logic                    accum_reset_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned DRAIN_W = (N > 1) ? $clog2(N) : 1;

    state_t               state;
    logic [K_WIDTH-1:0]   k_lat;
    logic [K_WIDTH-1:0]   beat_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 accept_c;
    logic                 last_beat_c;

    assign accept_c    = in_valid & in_ready;
    assign last_beat_c = accept_c && (beat_cnt == (k_lat - K_WIDTH'(1)));

    // Tile sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            k_lat           <= '0;
            beat_cnt        <= '0;
            drain_cnt       <= '0;
            in_ready        <= 1'b0;
            accum_reset_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            accum_reset_out <= 1'b0;
            done            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len != '0) begin
                            k_lat           <= k_len;
                            beat_cnt        <= '0;
                            accum_reset_out <= 1'b1;
                            state           <= ST_CLR;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_CLR: begin
                    in_ready <= 1'b1;
                    state    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept_c) begin
                        beat_cnt <= beat_cnt + K_WIDTH'(1);
                        if (last_beat_c) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(N - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane i gets i+1 stages; non-accepted cycles enter as zero bubbles.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_c;
        assign lane_c = accept_c ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        skew_delay_line #(
            .DEPTH      (i + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_line (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (accept_c),
            .sample_data  (lane_c),
            .tap_valid    (out_valid[i]),
            .tap_data     (out_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
